// File: rtl/rl_queue_reader.sv
// Drains words from a fall-through queue and streams each one out as DBITS/OBITS narrow chunks.
// Define RL_QUEUE_READER_MSB_FIRST_EN to emit the most-significant chunk first (default: LSB first).
module rl_queue_reader #(
    parameter int DBITS = 32,
    parameter int OBITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ena_i,
    input  logic             q_empty_i,
    input  logic [DBITS-1:0] q_d_i,
    output logic             q_re_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OBITS-1:0] q_o,
    output logic             last_o
);

    localparam int R     = DBITS / OBITS;
    localparam int CBITS = $clog2(R);
    localparam logic [CBITS-1:0] LAST_CNT = CBITS'(R - 1);

    if ((DBITS % OBITS) != 0 || R < 2) begin : g_bad_params
        $error("rl_queue_reader: DBITS must be a multiple of OBITS with DBITS/OBITS >= 2");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [DBITS-1:0]   hold_q, hold_d;
    logic [CBITS-1:0]   cnt_q, cnt_d;
    logic               busy;
    logic               xfer;

    assign busy    = (state_q == BUSY);
    assign xfer    = ena_i & busy & ready_i;
    assign valid_o = busy;
    assign last_o  = busy & (cnt_q == LAST_CNT);

    // A new word is taken when idle, or in the same cycle the final chunk leaves, so words run back to back.
    assign q_re_o = rst_ni & ena_i & ~clr_i & ~q_empty_i & (~busy | (xfer & last_o));

`ifdef RL_QUEUE_READER_MSB_FIRST_EN
    assign q_o = hold_q[DBITS-1 -: OBITS];
`else
    assign q_o = hold_q[OBITS-1:0];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = IDLE;
            hold_d  = '0;
            cnt_d   = '0;
        end else if (ena_i) begin
            case (state_q)
                IDLE: begin
                    if (q_re_o) begin
                        state_d = BUSY;
                        hold_d  = q_d_i;
                        cnt_d   = '0;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (cnt_q != LAST_CNT) begin
`ifdef RL_QUEUE_READER_MSB_FIRST_EN
                            hold_d = hold_q << OBITS;
`else
                            hold_d = hold_q >> OBITS;
`endif
                            cnt_d  = cnt_q + CBITS'(1);
                        end else if (q_re_o) begin
                            hold_d = q_d_i;
                            cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rl_queue_reader.sv
// Randomized self-checking bench for rl_queue_reader (DBITS=32, OBITS=8) against a chunk-queue reference model.
// Honours RL_QUEUE_READER_MSB_FIRST_EN so the model matches whichever build is compiled.
module tb_rl_queue_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic        ena_i;
    logic        q_empty_i;
    logic [31:0] q_d_i;
    logic        q_re_o;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  q_o;
    logic        last_o;

    int cmp_count = 0;
    int err_count = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] src[$];
    int          head = 0;
    bit          zero_out = 1'b1;

    always #5 clk_i = ~clk_i;

    rl_queue_reader #(
        .DBITS(32),
        .OBITS(8)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_i),
        .ena_i    (ena_i),
        .q_empty_i(q_empty_i),
        .q_d_i    (q_d_i),
        .q_re_o   (q_re_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .q_o      (q_o),
        .last_o   (last_o)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    // A popped word becomes its sequence of chunks in emission order.
    function automatic void push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
`ifdef RL_QUEUE_READER_MSB_FIRST_EN
            exp_q.push_back(w[31 - 8*k -: 8]);
`else
            exp_q.push_back(w[8*k +: 8]);
`endif
        end
    endfunction

    task automatic apply_stimulus(input bit rst, input bit ena, input bit clr, input bit rdy, input bit hide);
        bit exp_re;
        @(negedge clk_i);
        rst_ni    = rst;
        ena_i     = ena;
        clr_i     = clr;
        ready_i   = rdy;
        q_empty_i = hide || (head >= src.size());
        q_d_i     = q_empty_i ? 32'($urandom) : src[head];
        if (!rst) begin
            exp_q.delete();
            zero_out = 1'b1;
        end
        #1;
        exp_re = rst && ena && !clr && !q_empty_i &&
                 (exp_q.size() == 0 || (rdy && exp_q.size() == 1));
        check_output("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
        check_output("last_o",  32'(last_o),  32'(exp_q.size() == 1));
        check_output("q_re_o",  32'(q_re_o),  32'(exp_re));
        if (exp_q.size() != 0)
            check_output("q_o", 32'(q_o), 32'(exp_q[0]));
        else if (zero_out)
            check_output("q_o_zero", 32'(q_o), 32'h0);
        @(posedge clk_i);
        if (rst) begin
            if (clr) begin
                exp_q.delete();
                zero_out = 1'b1;
            end else if (ena) begin
                if (exp_q.size() != 0 && rdy)
                    void'(exp_q.pop_front());
                if (exp_re) begin
                    push_word(src[head]);
                    head++;
                    zero_out = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst_ni    = 1'b0;
        clr_i     = 1'b0;
        ena_i     = 1'b1;
        q_empty_i = 1'b1;
        q_d_i     = '0;
        ready_i   = 1'b1;

        // Reset, then idle with an empty queue.
        repeat (2) apply_stimulus(0, 1, 0, 1, 0);
        repeat (3) apply_stimulus(1, 1, 0, 1, 0);

        // Single word.
        src.push_back(32'hA1B2C3D4);
        repeat (7) apply_stimulus(1, 1, 0, 1, 0);

        // Back-to-back words.
        src.push_back(32'h03020100);
        src.push_back(32'h07060504);
        repeat (11) apply_stimulus(1, 1, 0, 1, 0);

        // Backpressure on the second chunk.
        src.push_back(32'hA1B2C3D4);
        repeat (2) apply_stimulus(1, 1, 0, 1, 0);
        repeat (3) apply_stimulus(1, 1, 0, 0, 0);
        repeat (4) apply_stimulus(1, 1, 0, 1, 0);

        // Clear on the third chunk with another word waiting.
        src.push_back(32'hA1B2C3D4);
        src.push_back(32'h11223344);
        repeat (3) apply_stimulus(1, 1, 0, 1, 0);
        apply_stimulus(1, 1, 1, 1, 0);
        repeat (6) apply_stimulus(1, 1, 0, 1, 0);

        // Enable low mid-word, then asynchronous reset mid-word.
        src.push_back(32'hCAFEF00D);
        src.push_back(32'h5A5A0F0F);
        repeat (2) apply_stimulus(1, 1, 0, 1, 0);
        repeat (2) apply_stimulus(1, 0, 0, 1, 0);
        repeat (3) apply_stimulus(1, 1, 0, 1, 0);
        apply_stimulus(0, 1, 0, 1, 0);
        repeat (6) apply_stimulus(1, 1, 0, 1, 0);

        // Randomized traffic with gaps, stalls, clears and enable drops.
        for (int i = 0; i < 2000; i++) begin
            if (src.size() - head < 3)
                src.push_back(32'($urandom));
            apply_stimulus(($urandom_range(0, 499) != 0),
                           ($urandom_range(0, 9) != 0),
                           ($urandom_range(0, 39) == 0),
                           ($urandom_range(0, 9) < 7),
                           ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", cmp_count, err_count);
        $finish;
    end

endmodule
